// File: rtl/cpu_cycle_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer and its consumers.
// Holds the sequencer state encoding, the one-hot phase bit positions and
// the width of the memory wait counter. No ports.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    FAULT
  } state_t;

  // Bit positions within the one-hot phase bus {WB,EX,DE,FE}
  localparam int PH_FE = 0;
  localparam int PH_DE = 1;
  localparam int PH_EX = 2;
  localparam int PH_WB = 3;

  // Wait counter width; covers WAIT_MAX up to 255
  localparam int WAIT_W = 8;

  // One-hot phase for a state; IDLE and FAULT map to all zeros
  function automatic logic [3:0] phase_onehot(state_t s);
    logic [3:0] p;
    p = '0;
    case (s)
      FETCH:     p[PH_FE] = 1'b1;
      DECODE:    p[PH_DE] = 1'b1;
      EXECUTE:   p[PH_EX] = 1'b1;
      WRITEBACK: p[PH_WB] = 1'b1;
      default:   p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_if.sv
// Host-side bundle of the instruction-cycle sequencer.
// Ports: ce/run/step/halt_req/mem_ready driven by the host (master);
// phase/phase_start/instr_done/halted/timeout/instr_count driven by the sequencer (slave).
interface cpu_cycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             ce;
  logic             run;
  logic             step;
  logic             halt_req;
  logic             mem_ready;
  logic [3:0]       phase;
  logic             phase_start;
  logic             instr_done;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output ce, run, step, halt_req, mem_ready,
    input  phase, phase_start, instr_done, halted, timeout, instr_count
  );

  modport slave (
    input  ce, run, step, halt_req, mem_ready,
    output phase, phase_start, instr_done, halted, timeout, instr_count
  );

endinterface

// File: rtl/cpu_cycle_sequencer_wait_watchdog.sv
// Memory wait-state watchdog shared by the FETCH and EXECUTE phases.
// Ports: clk, rst (sync, active-low), en (advance qualifier), clr (restart count),
// expire (combinational: this enabled wait cycle is the WAIT_MAX-th in a row).
module wait_watchdog
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_MAX - 1);

  logic [WAIT_W-1:0] cnt;

  // Fires on the wait cycle whose increment would make the count reach WAIT_MAX
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || expire) cnt <= '0;
      else               cnt <= cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Instruction-cycle sequencer: steps FETCH/DECODE/EXECUTE/WRITEBACK on ce cycles,
// with run/step/halt control and a memory-wait timeout that parks in FAULT.
// Ports: clk, rst (sync, active-low), bus (slave side of cpu_cycle_sequencer_if).
module cpu_cycle_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_cycle_sequencer_if.slave  bus
);

  state_t state, state_next;
  logic   run_mode, run_mode_next;
  logic   halt_pend, halt_pend_next;
  logic   first;  // current state was entered on the previous ce cycle

  logic [3:0]       phase_q, phase_nx;
  logic             ps_q, ps_nx;
  logic             id_q, id_nx;
  logic             halted_q, halted_nx;
  logic             to_q, to_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  logic wd_clr, wd_expire;

  // Counter only runs while a memory phase is stalled
  assign wd_clr = bus.mem_ready || !((state == FETCH) || (state == EXECUTE));

  wait_watchdog #(.WAIT_MAX(WAIT_MAX)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.ce),
    .clr    (wd_clr),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      run_mode  <= 1'b0;
      halt_pend <= 1'b0;
      first     <= 1'b0;
    end else if (bus.ce) begin
      state     <= state_next;
      run_mode  <= run_mode_next;
      halt_pend <= halt_pend_next;
      first     <= (state_next != state);
    end
  end

  always_comb begin
    state_next     = state;
    run_mode_next  = run_mode;
    halt_pend_next = halt_pend;

    case (state)
      IDLE: begin
        if (bus.run) begin
          state_next    = FETCH;
          run_mode_next = 1'b1;
        end else if (bus.step) begin
          state_next    = FETCH;
          run_mode_next = 1'b0;
        end
      end
      FETCH: begin
        if (bus.mem_ready)  state_next = DECODE;
        else if (wd_expire) state_next = FAULT;
      end
      DECODE: state_next = EXECUTE;
      EXECUTE: begin
        if (bus.mem_ready)  state_next = WRITEBACK;
        else if (wd_expire) state_next = FAULT;
      end
      WRITEBACK: begin
        if (halt_pend || bus.halt_req || !run_mode) state_next = IDLE;
        else                                        state_next = FETCH;
      end
      default: state_next = FAULT;
    endcase

    // A stop request waits for the instruction boundary; WRITEBACK consumes it
    if (state == WRITEBACK)  halt_pend_next = 1'b0;
    else if (state != IDLE)  halt_pend_next = halt_pend || bus.halt_req;

    // Outputs report the state processed this cycle; a fault reports immediately
    phase_nx  = (state_next == FAULT) ? 4'b0000 : phase_onehot(state);
    ps_nx     = first && (phase_onehot(state) != 4'b0000) && (state_next != FAULT);
    id_nx     = (state == WRITEBACK);
    halted_nx = (state == IDLE) || (state_next == FAULT);
    to_nx     = to_q || (state_next == FAULT);
    cnt_nx    = (state == WRITEBACK) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q  <= '0;
      ps_q     <= 1'b0;
      id_q     <= 1'b0;
      halted_q <= 1'b1;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.ce) begin
      phase_q  <= phase_nx;
      ps_q     <= ps_nx;
      id_q     <= id_nx;
      halted_q <= halted_nx;
      to_q     <= to_nx;
      cnt_q    <= cnt_nx;
    end else begin
      ps_q <= 1'b0;
      id_q <= 1'b0;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_start = ps_q;
  assign bus.instr_done  = id_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = to_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Bench for cpu_cycle_sequencer: a 16-bit-count instance and a 4-bit-count
// instance share one stimulus stream; vectors are compared after each edge.
module tb_cpu_cycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ce, run, step, halt_req, mem_ready;

  cpu_cycle_sequencer_if #(.CNT_W(16)) bus();
  cpu_cycle_sequencer_if #(.CNT_W(4))  bus4();

  assign bus.ce = ce;          assign bus4.ce = ce;
  assign bus.run = run;        assign bus4.run = run;
  assign bus.step = step;      assign bus4.step = step;
  assign bus.halt_req = halt_req;   assign bus4.halt_req = halt_req;
  assign bus.mem_ready = mem_ready; assign bus4.mem_ready = mem_ready;

  cpu_cycle_sequencer #(.WAIT_MAX(15), .CNT_W(16)) u_dut (
    .clk (clk), .rst (rst), .bus (bus.slave)
  );
  cpu_cycle_sequencer #(.WAIT_MAX(15), .CNT_W(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (bus4.slave)
  );

  typedef struct {
    logic [5:0]  in;   // {rst, ce, run, step, halt_req, mem_ready}
    logic [3:0]  ph;
    logic        ps, id, hl, to;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   applied = 0;
  int   miscmp  = 0;

  task automatic add(input logic r, c, ru, s, h, m,
                     input logic [3:0] ph, input logic ps, id, hl, to, input int cnt);
    vec_t v;
    v.in  = {r, c, ru, s, h, m};
    v.ph  = ph; v.ps = ps; v.id = id; v.hl = hl; v.to = to;
    v.cnt = 16'(cnt);
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ph, input logic ps, id, hl, to,
                       input logic [15:0] cnt);
    logic [27:0] got, req;
    logic [3:0]  cnt4;
    cnt4 = cnt[3:0];
    got = {bus.phase, bus.phase_start, bus.instr_done, bus.halted, bus.timeout,
           bus.instr_count, bus4.instr_count};
    req = {ph, ps, id, hl, to, cnt, cnt4};
    applied++;
    if (got !== req) begin
      miscmp++;
      $display("FAIL %s: got ph=%h ps=%b id=%b halted=%b to=%b cnt=%0d cnt4=%0d, required ph=%h ps=%b id=%b halted=%b to=%b cnt=%0d cnt4=%0d",
               name, bus.phase, bus.phase_start, bus.instr_done, bus.halted, bus.timeout,
               bus.instr_count, bus4.instr_count, ph, ps, id, hl, to, cnt, cnt4);
    end
  endtask

  initial begin
    int pulses;
    {rst, ce, run, step, halt_req, mem_ready} = 6'b010001;

    // reset
    add(0,1,0,0,0,1, 0,0,0,1,0,0);
    add(0,1,0,0,0,1, 0,0,0,1,0,0);
    // continuous run: IDLE edge, then three instructions
    add(1,1,1,0,0,1, 0,0,0,1,0,0);
    for (int k = 0; k < 3; k++) begin
      add(1,1,1,0,0,1, 1,1,0,0,0,k);
      add(1,1,1,0,0,1, 2,1,0,0,0,k);
      add(1,1,1,0,0,1, 4,1,0,0,0,k);
      add(1,1,1,0,0,1, 8,1,1,0,0,k+1);
    end
    // halt_req during DECODE of the next instruction
    add(1,1,1,0,0,1, 1,1,0,0,0,3);
    add(1,1,1,0,1,1, 2,1,0,0,0,3);
    add(1,1,1,0,0,1, 4,1,0,0,0,3);
    add(1,1,0,0,0,1, 8,1,1,0,0,4);
    add(1,1,0,0,0,1, 0,0,0,1,0,4);
    add(1,1,0,0,0,1, 0,0,0,1,0,4);
    // single step
    add(1,1,0,1,0,1, 0,0,0,1,0,4);
    add(1,1,0,0,0,1, 1,1,0,0,0,4);
    add(1,1,0,0,0,1, 2,1,0,0,0,4);
    add(1,1,0,0,0,1, 4,1,0,0,0,4);
    add(1,1,0,0,0,1, 8,1,1,0,0,5);
    add(1,1,0,0,0,1, 0,0,0,1,0,5);
    // ce gating
    add(1,1,1,0,0,1, 0,0,0,1,0,5);
    add(1,0,1,0,0,1, 0,0,0,1,0,5);
    add(1,1,1,0,0,1, 1,1,0,0,0,5);
    add(1,0,1,0,0,1, 1,0,0,0,0,5);
    add(1,0,1,0,0,1, 1,0,0,0,0,5);
    add(1,1,1,0,0,1, 2,1,0,0,0,5);
    add(1,0,1,0,0,1, 2,0,0,0,0,5);
    add(1,1,1,0,0,1, 4,1,0,0,0,5);
    add(1,1,1,0,0,1, 8,1,1,0,0,6);
    add(1,0,1,0,0,1, 8,0,0,0,0,6);
    // halt_req in FETCH stops run mode at the boundary
    add(1,1,0,0,1,1, 1,1,0,0,0,6);
    add(1,1,0,0,0,1, 2,1,0,0,0,6);
    add(1,1,0,0,0,1, 4,1,0,0,0,6);
    add(1,1,0,0,0,1, 8,1,1,0,0,7);
    add(1,1,0,0,0,1, 0,0,0,1,0,7);
    // halt_req in IDLE is ignored; run still starts and keeps going
    add(1,1,1,0,1,1, 0,0,0,1,0,7);
    add(1,1,1,0,0,1, 1,1,0,0,0,7);
    add(1,1,1,0,0,1, 2,1,0,0,0,7);
    add(1,1,1,0,0,1, 4,1,0,0,0,7);
    add(1,1,1,0,0,1, 8,1,1,0,0,8);
    add(1,1,0,0,0,1, 1,1,0,0,0,8);
    add(1,1,0,0,0,1, 2,1,0,0,0,8);
    // reset mid-EXECUTE aborts without retiring
    add(0,1,0,0,0,1, 0,0,0,1,0,0);
    add(0,1,0,0,0,1, 0,0,0,1,0,0);
    add(1,1,0,0,0,1, 0,0,0,1,0,0);
    // run and step together: run wins, so WRITEBACK continues to FETCH
    add(1,1,1,1,0,1, 0,0,0,1,0,0);
    add(1,1,0,0,0,1, 1,1,0,0,0,0);
    add(1,1,0,0,0,1, 2,1,0,0,0,0);
    add(1,1,0,0,0,1, 4,1,0,0,0,0);
    add(1,1,0,0,0,1, 8,1,1,0,0,1);
    add(1,1,0,0,1,1, 1,1,0,0,0,1);
    add(1,1,0,0,0,1, 2,1,0,0,0,1);
    add(1,1,0,0,0,1, 4,1,0,0,0,1);
    add(1,1,0,0,0,1, 8,1,1,0,0,2);
    add(1,1,0,0,0,1, 0,0,0,1,0,2);

    for (int i = 0; i < tbl.size(); i++) begin
      {rst, ce, run, step, halt_req, mem_ready} = tbl[i].in;
      tick();
      check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].ps, tbl[i].id, tbl[i].hl, tbl[i].to, tbl[i].cnt);
    end

    // 14 FETCH wait cycles: still legal
    step = 1'b1; mem_ready = 1'b0;
    tick(); check("wait_start", 0,0,0,1,0,2);
    step = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(); check($sformatf("wait_fe%0d", i), 1, (i == 0), 0,0,0,2);
    end
    mem_ready = 1'b1;
    tick(); check("wait_fe_done", 1,0,0,0,0,2);
    tick(); check("wait_de", 2,1,0,0,0,2);
    tick(); check("wait_ex", 4,1,0,0,0,2);
    tick(); check("wait_wb", 8,1,1,0,0,3);
    tick(); check("wait_idle", 0,0,0,1,0,3);

    // 15 EXECUTE wait cycles: fault
    step = 1'b1;
    tick(); check("to_start", 0,0,0,1,0,3);
    step = 1'b0;
    tick(); check("to_fe", 1,1,0,0,0,3);
    tick(); check("to_de", 2,1,0,0,0,3);
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(); check($sformatf("to_ex%0d", i), 4, (i == 0), 0,0,0,3);
    end
    tick(); check("to_fault", 0,0,0,1,1,3);
    run = 1'b1; step = 1'b1; halt_req = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); check($sformatf("to_stuck%0d", i), 0,0,0,1,1,3);
    end
    rst = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    tick(); check("to_reset", 0,0,0,1,0,0);

    // 16 instructions: 4-bit counter wraps to 0
    rst = 1'b1; run = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (bus.instr_done) pulses++;
    end
    tick();
    if (bus.instr_done) pulses++;
    check("wrap", 8,1,1,0,0,16);
    applied++;
    if (pulses != 16) begin
      miscmp++;
      $display("FAIL wrap_pulses: got %0d instr_done pulses, required 16", pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule

// File: doc/cpu_cycle_sequencer.md
Name: cpu_cycle_sequencer

Overview:
- Instruction-cycle sequencer for the mini computer. It sits directly downstream of the clock stage and runs in that stage's output clock domain.
- Steps the datapath through FETCH / DECODE / EXECUTE / WRITEBACK phases, one step per qualified cycle (ce=1).
- Supports run, single-step and halt control, plus memory wait states with a timeout watchdog.
- Control unit and datapath consume the one-hot phase bus and the phase_start / instr_done strobes.

Parameters:
- WAIT_MAX, 15, ce-qualified cycles a phase may wait for mem_ready before fault; legal range 1..255
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock (clock-stage output domain)
- rst  in  1  reset, synchronous, active-low
- ce  in  1  advance qualifier; state and counters change only when ce=1
- run  in  1  level; start continuous execution from IDLE
- step  in  1  level; execute exactly one instruction from IDLE
- halt_req  in  1  request stop at next instruction boundary
- mem_ready  in  1  memory access complete (FETCH/EXECUTE)
- phase  out  4  one-hot {WB,EX,DE,FE}; 0 in IDLE/FAULT
- phase_start  out  1  one-cycle pulse on first cycle of each phase
- instr_done  out  1  one-cycle pulse when WRITEBACK retires
- halted  out  1  1 in IDLE or FAULT
- timeout  out  1  sticky fault flag
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk. rst sampled at posedge; rst=0 is a synchronous, active-low reset.
- Reset values:
  - State IDLE; phase=0, phase_start=0, instr_done=0.
  - halted=1, timeout=0, instr_count=0.
  - wait_cnt=0, run_mode=0, halt_pend=0.
- Reset mid-instruction aborts immediately; instr_count does not increment for the aborted instruction.
- ce=0: all registers hold. phase holds its value. phase_start and instr_done are forced 0.
- All transitions below require ce=1.
- State IDLE:
  - run=1 -> FETCH, run_mode=1.
  - Else step=1 -> FETCH, run_mode=0.
  - run and step both 1 -> run wins.
- State FETCH:
  - mem_ready=1 -> DECODE, wait_cnt=0.
  - Else wait_cnt++. When wait_cnt reaches WAIT_MAX -> FAULT.
- State DECODE: unconditionally -> EXECUTE.
- State EXECUTE: same wait and timeout rule as FETCH; mem_ready=1 -> WRITEBACK.
- State WRITEBACK:
  - Pulse instr_done; instr_count <= instr_count+1 (wraps to 0).
  - If halt_pend=1, or halt_req=1 this cycle, or run_mode=0 -> IDLE; halt_pend cleared.
  - Else -> FETCH.
- State FAULT:
  - Terminal until reset; timeout=1, halted=1, phase=0.
  - run, step and halt_req are ignored.
- halt_req handling:
  - Latched into halt_pend on any ce cycle while not IDLE.
  - Never aborts a phase mid-instruction.
  - Ignored in IDLE. run=1 with halt_req=1 in IDLE still starts.
- phase_start: asserted in the first ce=1 cycle after entering a phase state, registered with the state. It is not repeated during wait cycles.
- Latency:
  - From IDLE with run sampled at edge 0 and mem_ready=1: phase=FE after edge 1; instr_done asserted in the cycle after edge 4.
  - Steady state is 4 ce-cycles per instruction plus wait cycles.
- step held high: exactly one instruction per IDLE entry. Re-entry to IDLE takes one cycle before step is sampled again, so a level step yields one instruction per 5 cycles. The host is expected to pulse step.
- Outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - State enum: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, FAULT.
  - Phase one-hot bit-index constants: PH_FE=0, PH_DE=1, PH_EX=2, PH_WB=3.
  - Reused by control unit and datapath.
- One natural sub-module, wait_watchdog: WAIT_MAX counter with clear, enable and expire outputs, reused for both memory phases.

Test Plan:
- Reset: rst=0 for 2 cycles mid-EXECUTE -> next cycle halted=1, phase=0, instr_count=0, no instr_done pulse.
- Continuous run: ce=1, mem_ready=1, run=1 for 12 cycles -> phase sequence 1,2,4,8 repeating, instr_done every 4th cycle, instr_count=3 after edge 12.
- Single step: step pulse one cycle -> exactly one FE/DE/EX/WB sequence, instr_count=1, then halted=1, phase=0.
- Halt: halt_req pulsed during DECODE of instruction 2 -> instruction 2 completes, instr_count=2, IDLE, halted=1.
- Wait and timeout:
  - mem_ready=0 in FETCH for 14 cycles, then 1 -> proceeds, 14 extra cycles, timeout=0.
  - mem_ready=0 for 15 cycles -> FAULT, timeout=1, run ignored until reset.
- ce gating and wrap:
  - ce toggling 1/0 -> phase advances only on ce=1 cycles.
  - CNT_W=4, 16 instructions -> instr_count wraps to 0.
